// File: rtl/imem_responder.sv
// Instruction-memory responder: returns a preloaded 16-bit word a fixed LATENCY after a fetch.
// Optional feature macro: IMEM_OOR_ERR_EN adds an oor_err flag for out-of-range fetches.
module imem_responder #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 2,
    parameter logic [15:0] OOR_INSTR  = 16'h0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [15:0]           PC,
    input  logic                  instrmem_rd,
    output logic [15:0]           Instr_dout,
    output logic                  complete_instr,
`ifdef IMEM_OOR_ERR_EN
    output logic                  oor_err,
`endif
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [15:0]           load_data
);

    localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("imem_responder: LATENCY must be in 1..15");
        end
        if (ADDR_WIDTH < 1 || ADDR_WIDTH > 16) begin : g_bad_addr_width
            $error("imem_responder: ADDR_WIDTH must be in 1..16");
        end
    endgenerate

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic        done_q, done_d;
    logic        addr_oor;
    logic [15:0] rdata;
    logic [15:0] mem [Depth];

    // Preload port; the array is deliberately not reset so an image survives reset.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    generate
        if (ADDR_WIDTH < 16) begin : g_oor
            assign addr_oor = |addr_q[15:ADDR_WIDTH];
        end else begin : g_no_oor
            assign addr_oor = 1'b0;
        end
    endgenerate

    // Combinational read of the old contents gives read-before-write on a colliding load.
    assign rdata = addr_oor ? OOR_INSTR : mem[addr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dout_d  = 16'h0000;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (instrmem_rd) begin
                    addr_d  = PC;
                    cnt_d   = CntInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    done_d  = 1'b1;
                    dout_d  = rdata;
                    state_d = StDone;
                end
            end
            // Request line is still high from the finished fetch, so it is ignored here.
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            dout_q  <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign Instr_dout     = dout_q;
    assign complete_instr = done_q;

`ifdef IMEM_OOR_ERR_EN
    logic oor_q, oor_d;

    always_comb begin
        oor_d = 1'b0;
        if (state_q == StWait && cnt_q == 4'd0) begin
            oor_d = addr_oor;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oor_q <= 1'b0;
        end else begin
            oor_q <= oor_d;
        end
    end

    assign oor_err = oor_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboarded bench for imem_responder: directed fetches push expected word, flag and cycle.
module tb_imem_responder;

    localparam int LAT = 2;
    localparam int AW  = 8;
`ifdef IMEM_OOR_ERR_EN
    localparam logic OOR_EXP = 1'b1;
`else
    localparam logic OOR_EXP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [15:0]   pc;
    logic          rd;
    logic [15:0]   dout;
    logic          complete;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic          oor_obs;

`ifdef IMEM_OOR_ERR_EN
    logic oor_err;
    assign oor_obs = oor_err;
`else
    assign oor_obs = 1'b0;
`endif

    imem_responder #(
        .ADDR_WIDTH(AW),
        .LATENCY   (LAT),
        .OOR_INSTR (16'h0000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .PC            (pc),
        .instrmem_rd   (rd),
        .Instr_dout    (dout),
        .complete_instr(complete),
`ifdef IMEM_OOR_ERR_EN
        .oor_err       (oor_err),
`endif
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data)
    );

    typedef struct {
        logic [15:0] data;
        logic        oor;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   end_req = 1'b0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every falling edge, compare outputs against the scoreboard or idle values.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            total += 1;
            if (complete !== 1'b0 || dout !== 16'h0000 || oor_obs !== 1'b0) begin
                bad += 1;
                $display("FAIL reset_outputs: got complete=%b dout=%h oor=%b, want 0 0000 0",
                         complete, dout, oor_obs);
            end
        end else if (complete === 1'b1) begin
            if (sb.size() == 0) begin
                total += 1;
                bad   += 1;
                $display("FAIL unexpected_pulse: got pulse dout=%h at cyc=%0d, want none",
                         dout, cyc);
            end else begin
                e = sb.pop_front();
                total += 3;
                if (dout !== e.data) begin
                    bad += 1;
                    $display("FAIL fetch_data: got %h, want %h", dout, e.data);
                end
                if (cyc != e.cyc) begin
                    bad += 1;
                    $display("FAIL fetch_cycle: got cyc=%0d, want cyc=%0d", cyc, e.cyc);
                end
                if (oor_obs !== e.oor) begin
                    bad += 1;
                    $display("FAIL oor_flag: got %b, want %b", oor_obs, e.oor);
                end
            end
        end else begin
            total += 1;
            if (complete !== 1'b0 || dout !== 16'h0000 || oor_obs !== 1'b0) begin
                bad += 1;
                $display("FAIL idle_outputs: got complete=%b dout=%h oor=%b, want 0 0000 0",
                         complete, dout, oor_obs);
            end
        end
        if (end_req) begin
            total += 1;
            if (sb.size() != 0) begin
                bad += 1;
                $display("FAIL missing_pulses: got %0d outstanding, want 0", sb.size());
            end
            end_req = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic wait_complete();
        int n = 0;
        while (complete !== 1'b1) begin
            tick();
            n++;
            if (n > 20) begin
                $display("FAIL timeout: got no complete_instr within 20 cycles, want pulse");
                $fatal(1, "bench stopped on timeout");
            end
        end
    endtask

    // Issue one fetch from IDLE; rd is held until the pulse is seen.
    task automatic fetch(input logic [15:0] a, input logic [15:0] d, input logic o);
        pc = a;
        rd = 1'b1;
        sb.push_back('{data: d, oor: o, cyc: cyc + 1 + LAT});
        wait_complete();
        rd = 1'b0;
        tick();
    endtask

    initial begin
        int c;
        reset     = 1'b1;
        pc        = 16'h0000;
        rd        = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = 16'h0000;
        tick();
        // Preload while still in reset: loads are accepted in every state.
        load(8'h05, 16'h1234);
        load(8'h00, 16'hA000);
        load(8'h01, 16'hA001);
        load(8'h07, 16'h7777);
        load(8'h03, 16'h3333);
        load(8'h09, 16'h1111);
        reset = 1'b0;
        tick();

        // Basic fetch.
        fetch(16'h0005, 16'h1234, 1'b0);

        // Back-to-back with rd held: completions LAT+2 cycles apart.
        pc = 16'h0000;
        rd = 1'b1;
        c  = cyc;
        sb.push_back('{data: 16'hA000, oor: 1'b0, cyc: c + 1 + LAT});
        sb.push_back('{data: 16'hA001, oor: 1'b0, cyc: c + 1 + LAT + LAT + 2});
        wait_complete();
        pc = 16'h0001;
        tick();
        wait_complete();
        rd = 1'b0;
        tick();

        // PC change and rd drop during WAIT are ignored.
        pc = 16'h0005;
        rd = 1'b1;
        sb.push_back('{data: 16'h1234, oor: 1'b0, cyc: cyc + 1 + LAT});
        tick();
        pc = 16'h0007;
        rd = 1'b0;
        wait_complete();
        tick();

        // Out-of-range addresses.
        fetch(16'h0100, 16'h0000, OOR_EXP);
        fetch(16'h8005, 16'h0000, OOR_EXP);
        fetch(16'h0007, 16'h7777, 1'b0);

        // Reset one cycle before the completing edge drops the fetch.
        pc = 16'h0003;
        rd = 1'b1;
        tick();
        repeat (LAT - 1) tick();
        reset = 1'b1;
        rd    = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        fetch(16'h0003, 16'h3333, 1'b0);

        // Load colliding with the completing edge: old word returned, new word next time.
        pc = 16'h0009;
        rd = 1'b1;
        sb.push_back('{data: 16'h1111, oor: 1'b0, cyc: cyc + 1 + LAT});
        tick();
        repeat (LAT - 1) tick();
        load_en   = 1'b1;
        load_addr = 8'h09;
        load_data = 16'hBEEF;
        tick();
        load_en = 1'b0;
        wait_complete();
        rd = 1'b0;
        tick();
        fetch(16'h0009, 16'hBEEF, 1'b0);

        repeat (3) tick();
        end_req = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
